// File: rtl/sc_ctrl_pkg.sv
// Shared constants for the stochastic-gate evaluation controller.
// State encodings and the default window-counter width.
package sc_ctrl_pkg;
  localparam int WIN_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
endpackage

// File: rtl/sc_xor_eval_ctrl_if.sv
// Signal bundle between the evaluation controller and its environment.
// master = controller side, slave = stimulus/consumer side.
interface sc_xor_eval_ctrl_if
  import sc_ctrl_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF
);
  logic                    INIT;
  logic                    START;
  logic [WIN_W-1:0]        WIN_LEN;
  logic                    ABORT;
  logic                    SC_OUT;
  logic                    EN;
  logic                    BUSY;
  logic [WIN_W-1:0]        RESULT;
  logic signed [WIN_W:0]   RESULT_BP;
  logic                    VALID;
  logic                    READY;

  modport master (
    input  INIT, START, WIN_LEN, ABORT,
    input  SC_OUT, READY,
    output EN, BUSY, RESULT, RESULT_BP, VALID
  );

  modport slave (
    output INIT, START, WIN_LEN, ABORT,
    output SC_OUT, READY,
    input  EN, BUSY, RESULT, RESULT_BP, VALID
  );
endinterface

// File: rtl/sc_win_counter.sv
// Loadable down-counter for the evaluation window.
// last flags the final cycle (remaining == 1).
module sc_win_counter #(
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIN_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);
  logic [WIN_W-1:0] cnt_q;
  logic [WIN_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      load:    cnt_d = load_val;
      dec:     cnt_d = cnt_q - WIN_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign last = (cnt_q == WIN_W'(1));
endmodule

// File: rtl/sc_xor_eval_ctrl.sv
// Runs one L-cycle window of a stochastic XOR gate and counts ones.
// Result is held as unsigned count and bipolar 2*ones-L until taken.
module sc_xor_eval_ctrl
  import sc_ctrl_pkg::*;
#(
  parameter int N     = 3,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic                  CLK,
  input  logic                  INIT,
  input  logic                  START,
  input  logic [WIN_W-1:0]      WIN_LEN,
  input  logic                  ABORT,
  input  logic                  SC_OUT,
  output logic                  EN,
  output logic                  BUSY,
  output logic [WIN_W-1:0]      RESULT,
  output logic signed [WIN_W:0] RESULT_BP,
  output logic                  VALID,
  input  logic                  READY
);
  if (N < 2) begin : g_bad_n
    $error("sc_xor_eval_ctrl: N must be >= 2");
  end

  logic [1:0]            state_q, state_d;
  logic                  en_q, en_d;
  logic [WIN_W-1:0]      acc_q, acc_d;
  logic [WIN_W-1:0]      len_q, len_d;
  logic [WIN_W-1:0]      res_q, res_d;
  logic signed [WIN_W:0] bp_q, bp_d;
  logic [WIN_W-1:0]      sum;
  logic                  start_ok;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic                  cnt_last;

  sc_win_counter #(.WIN_W(WIN_W)) u_cnt (
    .clk      (CLK),
    .rst      (INIT),
    .load     (cnt_load),
    .load_val (WIN_LEN),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  assign start_ok = START && (WIN_LEN != '0);
  assign sum      = acc_q + WIN_W'(SC_OUT);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    len_d    = len_q;
    res_d    = res_q;
    bp_d     = bp_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d  = ST_RUN;
          len_d    = WIN_LEN;
          acc_d    = '0;
          cnt_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
          acc_d   = sum;
          if (cnt_last) begin
            state_d = ST_HOLD;
            res_d   = sum;
            // (WIN_W+1)-bit wrap gives exact two's complement
            bp_d    = $signed({sum, 1'b0} - {1'b0, len_q});
          end
        end
      end
      ST_HOLD: begin
        if (READY) begin
          if (start_ok) begin
            state_d  = ST_RUN;
            len_d    = WIN_LEN;
            acc_d    = '0;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign en_d = (state_d == ST_RUN);

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      acc_q   <= '0;
      len_q   <= '0;
      res_q   <= '0;
      bp_q    <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      res_q   <= res_d;
      bp_q    <= bp_d;
    end
  end

  assign EN        = en_q;
  assign BUSY      = (state_q == ST_RUN) || (state_q == ST_HOLD);
  assign VALID     = (state_q == ST_HOLD);
  assign RESULT    = res_q;
  assign RESULT_BP = bp_q;
endmodule

// File: tb/tb_sc_xor_eval_ctrl.sv
// Randomised bench for sc_xor_eval_ctrl against a ones-count model.
// Expected results come from the bits the bench itself drove.
module tb_sc_xor_eval_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  sc_xor_eval_ctrl_if #(.WIN_W(W)) bus ();

  sc_xor_eval_ctrl #(.N(3), .WIN_W(W)) dut (
    .CLK       (clk),
    .INIT      (bus.INIT),
    .START     (bus.START),
    .WIN_LEN   (bus.WIN_LEN),
    .ABORT     (bus.ABORT),
    .SC_OUT    (bus.SC_OUT),
    .EN        (bus.EN),
    .BUSY      (bus.BUSY),
    .RESULT    (bus.RESULT),
    .RESULT_BP (bus.RESULT_BP),
    .VALID     (bus.VALID),
    .READY     (bus.READY)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int last_res     = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one window; reports EN cycles, VALID latency and ones driven.
  task automatic run_window(
    input  int          l,
    input  int          mode,
    input  logic [31:0] pat,
    input  bit          noise,
    output int          en_cnt,
    output int          lat,
    output int          ones
  );
    logic b;
    en_cnt = 0;
    lat    = -1;
    ones   = 0;
    bus.START   = 1'b1;
    bus.WIN_LEN = W'(l);
    bus.SC_OUT  = 1'b0;
    step();
    bus.START = 1'b0;
    for (int c = 1; c <= l + 20; c++) begin
      if (bus.VALID === 1'b1) begin
        lat = c;
        break;
      end
      if (bus.EN === 1'b1) begin
        case (mode)
          0:       b = 1'b0;
          1:       b = 1'b1;
          2:       b = pat[en_cnt];
          default: b = 1'($urandom_range(0, 1));
        endcase
        en_cnt++;
        ones += int'(b);
        bus.SC_OUT = b;
        if (noise) begin
          bus.START   = 1'($urandom_range(0, 1));
          bus.WIN_LEN = W'($urandom_range(1, 255));
          bus.READY   = 1'($urandom_range(0, 1));
        end
      end else begin
        bus.SC_OUT = 1'($urandom_range(0, 1));
        bus.START  = 1'b0;
        bus.READY  = 1'b0;
      end
      step();
    end
    bus.START  = 1'b0;
    bus.READY  = 1'b0;
    bus.SC_OUT = 1'b0;
  endtask

  task automatic consume();
    bus.READY = 1'b1;
    step();
    bus.READY = 1'b0;
    tests_run++;
    if (bus.VALID !== 1'b0 || bus.BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL consume: valid=%b busy=%b want 0 0",
               bus.VALID, bus.BUSY);
    end
  endtask

  task automatic check_window(
    input string name, input int l,
    input int en_cnt, input int lat, input int ones
  );
    tests_run++;
    if (en_cnt != l || lat != l + 1) begin
      tests_failed++;
      $display("FAIL %s timing: en=%0d lat=%0d want %0d %0d",
               name, en_cnt, lat, l, l + 1);
    end
    tests_run++;
    if (bus.RESULT !== W'(ones) ||
        bus.RESULT_BP !== (W+1)'(2 * ones - l)) begin
      tests_failed++;
      $display("FAIL %s result: got %0d/%0d want %0d/%0d", name,
               bus.RESULT, bus.RESULT_BP, ones, 2 * ones - l);
    end
    last_res = ones;
  endtask

  task automatic test_reset();
    bus.INIT = 1'b1;
    step();
    step();
    bus.INIT = 1'b0;
    tests_run++;
    if ({bus.EN, bus.BUSY, bus.VALID} !== 3'b000 ||
        bus.RESULT !== '0 || bus.RESULT_BP !== '0) begin
      tests_failed++;
      $display("FAIL reset: en=%b busy=%b valid=%b res=%0d bp=%0d",
               bus.EN, bus.BUSY, bus.VALID, bus.RESULT, bus.RESULT_BP);
    end
  endtask

  task automatic test_basic();
    int e, lt, o;
    run_window(4, 2, 32'hD, 1'b0, e, lt, o);
    tests_run++;
    if (e != 4 || lt != 5) begin
      tests_failed++;
      $display("FAIL basic timing: en=%0d lat=%0d want 4 5", e, lt);
    end
    tests_run++;
    if (bus.RESULT !== 8'd3 || bus.RESULT_BP !== 9'sd2) begin
      tests_failed++;
      $display("FAIL basic result: got %0d/%0d want 3/2",
               bus.RESULT, bus.RESULT_BP);
    end
    last_res = 3;
    consume();
  endtask

  task automatic test_full_window();
    int e, lt, o;
    run_window(255, 0, '0, 1'b0, e, lt, o);
    tests_run++;
    if (e != 255 || lt != 256 || bus.RESULT !== 8'd0 ||
        bus.RESULT_BP !== -9'sd255) begin
      tests_failed++;
      $display("FAIL full0: en=%0d lat=%0d res=%0d bp=%0d",
               e, lt, bus.RESULT, bus.RESULT_BP);
    end
    consume();
    run_window(255, 1, '0, 1'b0, e, lt, o);
    tests_run++;
    if (e != 255 || lt != 256 || bus.RESULT !== 8'd255 ||
        bus.RESULT_BP !== 9'sd255) begin
      tests_failed++;
      $display("FAIL full1: en=%0d lat=%0d res=%0d bp=%0d",
               e, lt, bus.RESULT, bus.RESULT_BP);
    end
    last_res = 255;
    consume();
  endtask

  task automatic test_zero_len();
    bus.START   = 1'b1;
    bus.WIN_LEN = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if ({bus.EN, bus.BUSY, bus.VALID} !== 3'b000) begin
        tests_failed++;
        $display("FAIL zero_len c%0d: en/busy/valid=%b want 000",
                 i, {bus.EN, bus.BUSY, bus.VALID});
      end
    end
    bus.START = 1'b0;
  endtask

  task automatic test_abort();
    bus.START   = 1'b1;
    bus.WIN_LEN = 8'd8;
    step();
    bus.START = 1'b0;
    bus.SC_OUT = 1'b1;
    step();
    step();
    bus.ABORT = 1'b1;
    step();
    bus.ABORT = 1'b0;
    tests_run++;
    if (bus.EN !== 1'b0 || bus.BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort: en=%b busy=%b want 0 0", bus.EN, bus.BUSY);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if (bus.VALID !== 1'b0 || bus.RESULT !== W'(last_res)) begin
        tests_failed++;
        $display("FAIL abort hold c%0d: valid=%b res=%0d want 0 %0d",
                 i, bus.VALID, bus.RESULT, last_res);
      end
    end
    bus.SC_OUT = 1'b0;
  endtask

  task automatic test_back_to_back();
    int e, lt, o;
    logic b0, b1;
    run_window(6, 3, '0, 1'b0, e, lt, o);
    check_window("b2b_first", 6, e, lt, o);
    for (int i = 0; i < 5; i++) begin
      bus.START = 1'b1;
      bus.WIN_LEN = 8'd2;
      step();
      tests_run++;
      if (bus.VALID !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b hold c%0d: valid=%b want 1", i, bus.VALID);
      end
    end
    bus.READY = 1'b1;
    step();
    bus.READY = 1'b0;
    bus.START = 1'b0;
    b0 = 1'($urandom_range(0, 1));
    b1 = 1'($urandom_range(0, 1));
    tests_run++;
    if (bus.VALID !== 1'b0 || bus.EN !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b c1: valid=%b en=%b want 0 1",
               bus.VALID, bus.EN);
    end
    bus.SC_OUT = b0;
    step();
    tests_run++;
    if (bus.EN !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b c2: en=%b want 1", bus.EN);
    end
    bus.SC_OUT = b1;
    step();
    bus.SC_OUT = 1'b0;
    o = int'(b0) + int'(b1);
    tests_run++;
    if (bus.EN !== 1'b0 || bus.VALID !== 1'b1 ||
        bus.RESULT !== W'(o) || bus.RESULT_BP !== (W+1)'(2 * o - 2)) begin
      tests_failed++;
      $display("FAIL b2b c3: en=%b valid=%b res=%0d bp=%0d want ones %0d",
               bus.EN, bus.VALID, bus.RESULT, bus.RESULT_BP, o);
    end
    last_res = o;
    consume();
  endtask

  task automatic test_init_mid();
    int e, lt, o;
    bus.START   = 1'b1;
    bus.WIN_LEN = 8'd8;
    step();
    bus.START  = 1'b0;
    bus.SC_OUT = 1'b1;
    step();
    step();
    bus.INIT  = 1'b1;
    bus.READY = 1'b1;
    bus.ABORT = 1'b1;
    step();
    bus.INIT  = 1'b0;
    bus.READY = 1'b0;
    bus.ABORT = 1'b0;
    tests_run++;
    if ({bus.EN, bus.BUSY, bus.VALID} !== 3'b000 ||
        bus.RESULT !== '0 || bus.RESULT_BP !== '0) begin
      tests_failed++;
      $display("FAIL init_run: en=%b busy=%b valid=%b res=%0d bp=%0d",
               bus.EN, bus.BUSY, bus.VALID, bus.RESULT, bus.RESULT_BP);
    end
    run_window(5, 3, '0, 1'b0, e, lt, o);
    check_window("init_run_after", 5, e, lt, o);
    bus.INIT  = 1'b1;
    bus.START = 1'b1;
    step();
    bus.INIT  = 1'b0;
    bus.START = 1'b0;
    tests_run++;
    if ({bus.EN, bus.BUSY, bus.VALID} !== 3'b000 ||
        bus.RESULT !== '0 || bus.RESULT_BP !== '0) begin
      tests_failed++;
      $display("FAIL init_hold: en=%b busy=%b valid=%b res=%0d bp=%0d",
               bus.EN, bus.BUSY, bus.VALID, bus.RESULT, bus.RESULT_BP);
    end
    run_window(3, 3, '0, 1'b0, e, lt, o);
    check_window("init_hold_after", 3, e, lt, o);
    consume();
  endtask

  task automatic test_random();
    int e, lt, o, l, gap;
    for (int k = 0; k < 25; k++) begin
      l = $urandom_range(1, 40);
      run_window(l, 3, '0, 1'b1, e, lt, o);
      check_window("random", l, e, lt, o);
      gap = $urandom_range(0, 3);
      for (int i = 0; i < gap; i++) begin
        bus.ABORT = 1'($urandom_range(0, 1));
        step();
      end
      bus.ABORT = 1'b0;
      tests_run++;
      if (bus.VALID !== 1'b1 || bus.RESULT !== W'(o)) begin
        tests_failed++;
        $display("FAIL random hold: valid=%b res=%0d want 1 %0d",
                 bus.VALID, bus.RESULT, o);
      end
      consume();
    end
  endtask

  initial begin
    bus.INIT    = 1'b1;
    bus.START   = 1'b0;
    bus.WIN_LEN = '0;
    bus.ABORT   = 1'b0;
    bus.SC_OUT  = 1'b0;
    bus.READY   = 1'b0;
    test_reset();
    test_basic();
    test_full_window();
    test_zero_len();
    test_abort();
    test_back_to_back();
    test_init_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/sc_xor_eval_ctrl.md
SC_XOR_EVAL_CTRL -- requirements
Module: sc_xor_eval_ctrl

Interface
REQ-001 SHALL have parameter N, default 3: input count of the controlled cascaded-XOR stochastic gate; used only for reporting, no datapath effect.
REQ-002 SHALL have parameter WIN_W, default 8: width of window length and ones count; maximum window 2^WIN_W-1 cycles.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state changes on rising edge.
REQ-004 SHALL have port INIT, input, 1: synchronous active-high reset.
REQ-005 SHALL have port START, input, 1: request one evaluation window.
REQ-006 SHALL have port WIN_LEN, input, WIN_W: window length L in cycles; sampled only when START is accepted.
REQ-007 SHALL have port ABORT, input, 1: cancel the running window.
REQ-008 SHALL have port SC_OUT, input, 1: gate output bitstream; combinational from EN, so sampled in the same cycle EN is high.
REQ-009 SHALL have port EN, output, 1: drives the gate enable.
REQ-010 SHALL have port BUSY, output, 1: high in RUN and HOLD.
REQ-011 SHALL have port RESULT, output, WIN_W: ones count of the last completed window.
REQ-012 SHALL have port RESULT_BP, output, WIN_W+1 signed: bipolar value 2*RESULT - L.
REQ-013 SHALL have port VALID, output, 1: result available; held until READY.
REQ-014 SHALL have port READY, input, 1: consumer accepts the result.

Function
REQ-015 SHALL implement states IDLE, RUN and HOLD.
REQ-016 SHALL, in IDLE, accept START only when WIN_LEN != 0: latch L, clear accumulator, go to RUN.
REQ-017 SHALL, in IDLE, ignore START with WIN_LEN == 0: no state change, no VALID.
REQ-018 SHALL register EN and hold it high in exactly the L cycles of RUN; START accepted at cycle t gives EN high in cycles t+1..t+L.
REQ-019 SHALL, in each RUN cycle, add SC_OUT to the accumulator and decrement the remaining-cycle counter.
REQ-020 SHALL, on the RUN cycle with remaining == 1, load RESULT = accumulator + SC_OUT, load RESULT_BP, and enter HOLD; VALID rises in cycle t+L+1.
REQ-021 SHALL compute RESULT_BP as a signed (WIN_W+1)-bit value with no overflow for any L <= 2^WIN_W-1.
REQ-022 SHALL keep EN low and RESULT/RESULT_BP stable in HOLD and IDLE.
REQ-023 SHALL, in HOLD, hold VALID high until a cycle with READY high; that cycle completes the transfer.
REQ-024 SHALL, in HOLD, on READY with START and WIN_LEN != 0 in the same cycle, go directly to RUN; otherwise go to IDLE on READY.
REQ-025 SHALL ignore START during RUN.
REQ-026 SHALL, on ABORT in RUN, go to IDLE next cycle: EN low, no VALID, RESULT unchanged; ABORT overrides window completion in the same cycle.
REQ-027 SHALL ignore ABORT in IDLE and HOLD.
REQ-028 SHALL give READY no effect outside HOLD.

Reset
REQ-029 SHALL, with INIT high at a rising edge, force IDLE, EN=0, BUSY=0, VALID=0, RESULT=0, RESULT_BP=0, and clear the accumulator and counter.
REQ-030 SHALL give INIT priority over START, ABORT and READY, including mid-RUN and mid-HOLD.

Structure
REQ-031 SHALL take state encodings (IDLE=2'd0, RUN=2'd1, HOLD=2'd2) and default WIN_W from shared package sc_ctrl_pkg.
REQ-032 SHALL place the loadable down-counter with terminal-count flag in sub-module sc_win_counter, parameterised by WIN_W.
REQ-033 SHALL keep the FSM, accumulator and result registers in sc_xor_eval_ctrl.

Verification
REQ-034 SHALL cover: INIT then START, WIN_LEN=4, SC_OUT=1,0,1,1 -> EN high exactly 4 cycles; RESULT=3, RESULT_BP=+2, VALID in cycle 5 after START.
REQ-035 SHALL cover: WIN_LEN=255, SC_OUT held 0 -> RESULT=0, RESULT_BP=-255; SC_OUT held 1 -> RESULT=255, RESULT_BP=+255.
REQ-036 SHALL cover: START with WIN_LEN=0 in IDLE -> state stays IDLE, EN=0, VALID never rises.
REQ-037 SHALL cover: ABORT at the 3rd RUN cycle of an L=8 window -> EN low next cycle, no VALID, RESULT keeps its prior value.
REQ-038 SHALL cover: VALID held with READY low for 5 cycles, then READY+START with WIN_LEN=2 -> VALID drops, RUN entered with no IDLE cycle, EN high 2 cycles.
REQ-039 SHALL cover: INIT asserted mid-RUN and mid-HOLD -> all outputs zero next cycle, then a new START runs normally.
